// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
//   fwd_sel_t  : E-stage operand mux select (register file / M-stage ALU / W-stage result)
//   hz_state_t : hazard FSM states
//   CNT_W      : width of the shared stall/flush down-counter
package hazard_pkg;

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN,
    LOAD_STALL,
    BR_FLUSH
  } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// Bundle between the 5-stage pipeline datapath and the hazard unit.
//   master : pipeline side, drives stage register addresses/controls, receives selects/stalls
//   slave  : hazard unit side
// perf_* carry the optional performance counters (zero when HAZARD_PERF_EN is undefined).
interface pipeline_hazard_unit_if
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 4
);
  logic              id_valid;
  logic [REG_AW-1:0] id_ra;
  logic [REG_AW-1:0] id_rb;
  logic              id_use_a;
  logic              id_use_b;
  logic              branch_taken;
  logic [REG_AW-1:0] ex_ra;
  logic [REG_AW-1:0] ex_rb;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_regw;
  logic              ex_memtoreg;
  logic [REG_AW-1:0] m_rd;
  logic              m_regw;
  logic              m_memtoreg;
  logic [REG_AW-1:0] w_rd;
  logic              w_regw;
  logic              ext_stall;
  fwd_sel_t          fwd_a_sel;
  fwd_sel_t          fwd_b_sel;
  logic              stall_f;
  logic              stall_d;
  logic              flush_d;
  logic              flush_e;
  logic [31:0]       perf_stall_cnt;
  logic [31:0]       perf_flush_cnt;

  modport master (
    output id_valid, id_ra, id_rb, id_use_a, id_use_b, branch_taken,
    output ex_ra, ex_rb, ex_rd, ex_regw, ex_memtoreg,
    output m_rd, m_regw, m_memtoreg, w_rd, w_regw, ext_stall,
    input  fwd_a_sel, fwd_b_sel, stall_f, stall_d, flush_d, flush_e,
    input  perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  id_valid, id_ra, id_rb, id_use_a, id_use_b, branch_taken,
    input  ex_ra, ex_rb, ex_rd, ex_regw, ex_memtoreg,
    input  m_rd, m_regw, m_memtoreg, w_rd, w_regw, ext_stall,
    output fwd_a_sel, fwd_b_sel, stall_f, stall_d, flush_d, flush_e,
    output perf_stall_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_unit_fwd_select.sv
// Per-operand forwarding comparator (purely combinational).
//   ex_r                  : E-stage source register of this operand
//   m_rd/m_regw/m_memtoreg: M-stage destination, write enable, is-load
//   w_rd/w_regw           : W-stage destination, write enable
//   sel                   : FWD_MEM beats FWD_WB beats FWD_REG
module fwd_select
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW  = 4,
  parameter bit          R0_ZERO = 1'b0
) (
  input  logic [REG_AW-1:0] ex_r,
  input  logic [REG_AW-1:0] m_rd,
  input  logic              m_regw,
  input  logic              m_memtoreg,
  input  logic [REG_AW-1:0] w_rd,
  input  logic              w_regw,
  output fwd_sel_t          sel
);

  always_comb begin
    sel = FWD_REG;
    if (R0_ZERO && (ex_r == '0)) begin
      sel = FWD_REG;
    end else if (m_regw && !m_memtoreg && (m_rd == ex_r)) begin
      // A load still in M has no data yet; the load-use stall routes it through W instead.
      sel = FWD_MEM;
    end else if (w_regw && (w_rd == ex_r)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard and forwarding controller for a 5-stage F/D/E/M/W pipeline.
//   clk, rst : clock (rising edge), asynchronous active-low reset
//   hz       : slave side of pipeline_hazard_unit_if (stage info in, selects/stalls/flushes out)
// Parameters: REG_AW, LOAD_LAT (extra load cycles, 0..7), BR_PENALTY (1..7), R0_ZERO.
// Optional feature macro: HAZARD_PERF_EN enables saturating stall/flush performance counters.
module pipeline_hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW     = 4,
  parameter int unsigned LOAD_LAT   = 0,
  parameter int unsigned BR_PENALTY = 1,
  parameter bit          R0_ZERO    = 1'b0
) (
  input logic             clk,
  input logic             rst,
  pipeline_hazard_unit_if.slave hz
);

  localparam logic [CNT_W-1:0] LoadCnt = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] BrCnt   = CNT_W'(BR_PENALTY - 1);

  fwd_sel_t  sel_a, sel_b;
  hz_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic load_use;
  logic stall_f_c, stall_d_c, flush_d_c, flush_e_c;

  fwd_select #(.REG_AW(REG_AW), .R0_ZERO(R0_ZERO)) u_fwd_a (
    .ex_r       (hz.ex_ra),
    .m_rd       (hz.m_rd),
    .m_regw     (hz.m_regw),
    .m_memtoreg (hz.m_memtoreg),
    .w_rd       (hz.w_rd),
    .w_regw     (hz.w_regw),
    .sel        (sel_a)
  );

  fwd_select #(.REG_AW(REG_AW), .R0_ZERO(R0_ZERO)) u_fwd_b (
    .ex_r       (hz.ex_rb),
    .m_rd       (hz.m_rd),
    .m_regw     (hz.m_regw),
    .m_memtoreg (hz.m_memtoreg),
    .w_rd       (hz.w_rd),
    .w_regw     (hz.w_regw),
    .sel        (sel_b)
  );

  // A load targeting r0 (when hardwired) never creates a dependency.
  assign load_use = hz.id_valid && hz.ex_regw && hz.ex_memtoreg &&
                    !(R0_ZERO && (hz.ex_rd == '0)) &&
                    ((hz.id_use_a && (hz.id_ra == hz.ex_rd)) ||
                     (hz.id_use_b && (hz.id_rb == hz.ex_rd)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_f_c = 1'b0;
    stall_d_c = 1'b0;
    flush_d_c = 1'b0;
    flush_e_c = 1'b0;
    if (hz.ext_stall) begin
      // Freeze: hold the front end and all hazard state, consume nothing.
      stall_f_c = 1'b1;
      stall_d_c = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (load_use) begin
            // Any simultaneous taken branch is re-presented by the held decode stage.
            stall_f_c = 1'b1;
            stall_d_c = 1'b1;
            flush_e_c = 1'b1;
            if (LOAD_LAT > 0) begin
              state_d = LOAD_STALL;
              cnt_d   = LoadCnt;
            end
          end else if (hz.id_valid && hz.branch_taken) begin
            flush_d_c = 1'b1;
            if (BR_PENALTY > 1) begin
              state_d = BR_FLUSH;
              cnt_d   = BrCnt;
            end
          end
        end
        LOAD_STALL: begin
          stall_f_c = 1'b1;
          stall_d_c = 1'b1;
          flush_e_c = 1'b1;
          cnt_d     = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = RUN;
        end
        BR_FLUSH: begin
          flush_d_c = 1'b1;
          cnt_d     = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Outputs are forced low while reset is asserted, regardless of the inputs.
  assign hz.fwd_a_sel = rst ? sel_a : FWD_REG;
  assign hz.fwd_b_sel = rst ? sel_b : FWD_REG;
  assign hz.stall_f   = rst & stall_f_c;
  assign hz.stall_d   = rst & stall_d_c;
  assign hz.flush_d   = rst & flush_d_c;
  assign hz.flush_e   = rst & flush_e_c;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_d_c && !hz.ext_stall && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (flush_d_c && (perf_flush_q != 32'hFFFF_FFFF)) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign hz.perf_stall_cnt = perf_stall_q;
  assign hz.perf_flush_cnt = perf_flush_q;
`else
  assign hz.perf_stall_cnt = 32'd0;
  assign hz.perf_flush_cnt = 32'd0;
`endif

endmodule
